fwd_hazard_unit: RTL and testbench
==================================

// Module: fwd_hazard_unit
// PURPOSE
//  Producer side of the exec-stage forwarding interface: tracks destination-register tags down the
//  ID->EX->MEM->WB pipeline and drives the four 2-bit forwarding selects consumed by exec, plus
//  load-use stall and branch-flush bubble control. Sits beside the pipeline registers in core top.
//  Select encoding, all four outputs: 2'd0 = no forward, 2'd1 = MEM-stage data, 2'd2 = WB-stage data.
//  2'd3 is never driven.
// PARAMETERS
//  RW      3   register-index width (8 GPRs)
//  FWD_W   2   forwarding select width (fixed by exec mux4)
// PORTS
//  clk           in   1    core clock
//  rst_n         in   1    async active-low reset
//  id_valid      in   1    ID holds a real instruction
//  id_ra         in   RW   ID source register a (drives rd1 path)
//  id_rb         in   RW   ID source register b (drives rd2 path)
//  id_use_ra     in   1    ID instruction reads ra
//  id_use_rb     in   1    ID instruction reads rb
//  id_wreg       in   RW   ID destination register
//  id_regwrite   in   1    ID instruction writes a register
//  id_memread    in   1    ID instruction is a load
//  ex_srcA_reg   in   1    EX: ALUsrcA_controll selects rd2 (register operand)
//  ex_srcB_reg   in   1    EX: ALUsrcB_controll selects rd1 (register operand)
//  ex_flush      in   1    branch taken resolved in EX; kill ID and EX
//  fwdA          out  2    forwardingA_controll
//  fwdB          out  2    forwardingB_controll
//  fwd_ra        out  2    forwarding_ra_controll (rd1_ex2 path)
//  fwd_rb        out  2    forwarding_rb_controll (rd2_ex2 path)
//  stall         out  1    hold PC and IF/ID this cycle
//  bubble        out  1    insert NOP into ID/EX this cycle
// BEHAVIOUR
//  - State: three tag registers EX, MEM, WB; each holds {valid, wreg, regwrite, memread}.
//    EX also holds {ra, rb, use_ra, use_rb}.
//  - Every clock edge: WB<=MEM; MEM<=EX; EX<=ID fields, with valid = id_valid & ~bubble.
//  - Reset (async, rst_n=0): all valid bits 0.
//    All outputs combinationally 0 while in reset and in the first cycle after.
//  - Match(stage, r) = stage.valid & stage.regwrite & stage.wreg==r. r0 is not special.
//  - fwd_ra = EX.use_ra & Match(MEM,EX.ra) ? 1 : EX.use_ra & Match(WB,EX.ra) ? 2 : 0.
//    fwd_rb uses the same rule with rb. MEM has priority over WB (newest value wins).
//  - fwdB = ex_srcB_reg ? fwd_ra : 0.
//  - fwdA = ex_srcA_reg ? fwd_rb : 0.
//  - MEM match on a load (MEM.memread) never occurs: the load-use stall guarantees it.
//    Assertion: MEM.memread & Match(MEM, used src) is flagged in simulation.
//  - Load-use: stall = bubble = id_valid & EX.valid & EX.memread & EX.regwrite &
//    ((id_use_ra & EX.wreg==id_ra) | (id_use_rb & EX.wreg==id_rb)).
//    Exactly one cycle: the next cycle EX is a bubble, so the condition clears.
//  - Flush: ex_flush=1 -> bubble=1 and stall=0. At the edge, EX.valid<=0 and MEM<=EX is also
//    killed (MEM.valid<=0); WB advances normally.
//  - Flush and load-use in the same cycle: flush wins (stall=0, bubble=1).
//  - Outputs are combinational from registered tags and EX inputs. Latency 0 within the cycle.
//    Tags lag the datapath registers by exactly 0 stages: the same edges, the same enables.
//  - Reset asserted mid-stall: stall and bubble drop immediately (async), and all tags invalidate.
// STRUCTURE
//  - Shared package core_pkg: typedef fwd_sel_t (enum FWD_NONE=0, FWD_MEM=1, FWD_WB=2).
//    The same package holds typedef tag_t for the tag struct and localparam RW.
//  - One sub-module fwd_select: combinational {stage tags, src, use} -> fwd_sel_t.
//    It is instantiated twice, for ra and rb.
//  - Top level: tag flops, stall/flush logic, srcA/srcB gating.
// TESTING
//  - Reset: rst_n=0 while tags are full -> all six outputs 0; after release, 2 idle cycles -> still 0.
//  - MEM forward: ADD r3 then ADD r4,r3 (ra=3, srcB_reg=1) -> in cycle 2 fwd_ra=1, fwdB=1.
//  - WB forward: producer r5, one unrelated instruction, then consumer rb=5, srcA_reg=1
//    -> fwd_rb=2, fwdA=2.
//  - Priority: r2 is written twice in consecutive instructions, then read -> fwd=1 (MEM), not 2.
//  - Load-use: LD r1 then ADD ra=1 -> stall=bubble=1 for exactly one cycle.
//    The next cycle gives fwd_ra=2 and stall=0.
//  - Flush vs stall: load-use condition plus ex_flush=1 in the same cycle -> stall=0, bubble=1.
//    The next cycle EX.valid=0 and MEM.valid=0, and all fwd outputs are 0.
//  - Gating: Match present but ex_srcA_reg=0 -> fwdA=0 while fwd_rb stays 1.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types for the exec-stage forwarding/hazard logic: select encoding,
// pipeline tag layout and the tag-match helper.
package core_pkg;

    localparam int RW    = 3;
    localparam int FWD_W = 2;

    typedef enum logic [FWD_W-1:0] {
        FWD_NONE = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] wreg;
        logic          regwrite;
        logic          memread;
    } tag_t;

    // EX additionally remembers which sources the instruction reads.
    typedef struct packed {
        tag_t          t;
        logic [RW-1:0] ra;
        logic [RW-1:0] rb;
        logic          use_ra;
        logic          use_rb;
    } ex_tag_t;

    function automatic logic tag_match(input tag_t t, input logic [RW-1:0] r);
        return t.valid & t.regwrite & (t.wreg == r);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-source forwarding select: MEM producer wins over WB producer.
module fwd_select
    import core_pkg::*;
(
    input  tag_t          i_mem,
    input  tag_t          i_wb,
    input  logic [RW-1:0] i_src,
    input  logic          i_use,
    output fwd_sel_t      o_sel,
    output logic          o_mem_hit
);

    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = i_use & tag_match(i_mem, i_src);
    assign w_wb_hit  = i_use & tag_match(i_wb, i_src);
    assign o_mem_hit = w_mem_hit;

    always_comb begin
        o_sel = FWD_NONE;
        if (w_mem_hit)
            o_sel = FWD_MEM;
        else if (w_wb_hit)
            o_sel = FWD_WB;
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Tracks destination tags down ID->EX->MEM->WB and drives exec forwarding
// selects plus load-use stall and branch-flush bubble control.
module fwd_hazard_unit
    import core_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [RW-1:0]    id_ra,
    input  logic [RW-1:0]    id_rb,
    input  logic             id_use_ra,
    input  logic             id_use_rb,
    input  logic [RW-1:0]    id_wreg,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             ex_srcA_reg,
    input  logic             ex_srcB_reg,
    input  logic             ex_flush,
    output logic [FWD_W-1:0] fwdA,
    output logic [FWD_W-1:0] fwdB,
    output logic [FWD_W-1:0] fwd_ra,
    output logic [FWD_W-1:0] fwd_rb,
    output logic             stall,
    output logic             bubble
);

    ex_tag_t          r_ex;
    tag_t             r_mem;
    tag_t             r_wb;
    logic             r_live;

    logic             w_live;
    logic             w_flush;
    logic             w_lu;
    logic             w_bubble;
    logic             w_ex_vld;
    logic             w_hit_ra;
    logic             w_hit_rb;
    fwd_sel_t         w_sel_ra;
    fwd_sel_t         w_sel_rb;
    logic [FWD_W-1:0] w_ra;
    logic [FWD_W-1:0] w_rb;

    // Outputs stay quiet during reset and for the first cycle after release.
    assign w_live  = rst_n & r_live;
    assign w_flush = w_live & ex_flush;

    assign w_lu = w_live & id_valid & r_ex.t.valid & r_ex.t.memread & r_ex.t.regwrite &
                  ((id_use_ra & (r_ex.t.wreg == id_ra)) |
                   (id_use_rb & (r_ex.t.wreg == id_rb)));

    assign w_bubble = w_lu | w_flush;
    assign w_ex_vld = id_valid & ~w_bubble;

    fwd_select u_sel_ra (
        .i_mem     (r_mem),
        .i_wb      (r_wb),
        .i_src     (r_ex.ra),
        .i_use     (r_ex.use_ra),
        .o_sel     (w_sel_ra),
        .o_mem_hit (w_hit_ra)
    );

    fwd_select u_sel_rb (
        .i_mem     (r_mem),
        .i_wb      (r_wb),
        .i_src     (r_ex.rb),
        .i_use     (r_ex.use_rb),
        .o_sel     (w_sel_rb),
        .o_mem_hit (w_hit_rb)
    );

    assign w_ra   = {FWD_W{w_live}} & w_sel_ra;
    assign w_rb   = {FWD_W{w_live}} & w_sel_rb;
    assign fwd_ra = w_ra;
    assign fwd_rb = w_rb;
    assign fwdB   = ex_srcB_reg ? w_ra : FWD_W'(0);
    assign fwdA   = ex_srcA_reg ? w_rb : FWD_W'(0);
    assign stall  = w_lu & ~w_flush;
    assign bubble = w_bubble;

    // A bubble in EX reads nothing, so its use bits are cleared with valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live <= 1'b0;
            r_ex   <= '0;
            r_mem  <= '0;
            r_wb   <= '0;
        end else begin
            r_live           <= 1'b1;
            r_ex.t.valid     <= w_ex_vld;
            r_ex.t.wreg      <= id_wreg;
            r_ex.t.regwrite  <= id_regwrite;
            r_ex.t.memread   <= id_memread;
            r_ex.ra          <= id_ra;
            r_ex.rb          <= id_rb;
            r_ex.use_ra      <= w_ex_vld & id_use_ra;
            r_ex.use_rb      <= w_ex_vld & id_use_rb;
            r_mem.valid      <= r_ex.t.valid & ~w_flush;
            r_mem.wreg       <= r_ex.t.wreg;
            r_mem.regwrite   <= r_ex.t.regwrite;
            r_mem.memread    <= r_ex.t.memread;
            r_wb             <= r_mem;
        end
    end

    a_no_load_mem_fwd: assert property (@(posedge clk) disable iff (!rst_n)
        !(r_mem.memread && (w_hit_ra || w_hit_rb)))
        else $error("load result selected from MEM stage");

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench: driver pushes hand-computed expectations per cycle, monitor
// pops and compares on the falling edge.
module tb_fwd_hazard_unit;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [2:0] id_ra;
    logic [2:0] id_rb;
    logic       id_use_ra;
    logic       id_use_rb;
    logic [2:0] id_wreg;
    logic       id_regwrite;
    logic       id_memread;
    logic       ex_srcA_reg;
    logic       ex_srcB_reg;
    logic       ex_flush;
    logic [1:0] fwdA;
    logic [1:0] fwdB;
    logic [1:0] fwd_ra;
    logic [1:0] fwd_rb;
    logic       stall;
    logic       bubble;

    typedef struct {
        string      name;
        logic [9:0] val;
    } exp_t;

    exp_t q[$];
    int   total  = 0;
    int   passed = 0;

    fwd_hazard_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_ra       (id_ra),
        .id_rb       (id_rb),
        .id_use_ra   (id_use_ra),
        .id_use_rb   (id_use_rb),
        .id_wreg     (id_wreg),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .ex_srcA_reg (ex_srcA_reg),
        .ex_srcB_reg (ex_srcB_reg),
        .ex_flush    (ex_flush),
        .fwdA        (fwdA),
        .fwdB        (fwdB),
        .fwd_ra      (fwd_ra),
        .fwd_rb      (fwd_rb),
        .stall       (stall),
        .bubble      (bubble)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One pipeline cycle: inputs, then expected {fwdA,fwdB,fwd_ra,fwd_rb,stall,bubble}.
    task automatic step(input string nm, input logic rs,
                        input logic v, input logic [2:0] ra, input logic [2:0] rb,
                        input logic ua, input logic ub, input logic [2:0] wr,
                        input logic rw, input logic mr,
                        input logic sa, input logic sb, input logic fl,
                        input logic [1:0] ea, input logic [1:0] eb,
                        input logic [1:0] era, input logic [1:0] erb,
                        input logic est, input logic ebu);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n       = rs;
        id_valid    = v;
        id_ra       = ra;
        id_rb       = rb;
        id_use_ra   = ua;
        id_use_rb   = ub;
        id_wreg     = wr;
        id_regwrite = rw;
        id_memread  = mr;
        ex_srcA_reg = sa;
        ex_srcB_reg = sb;
        ex_flush    = fl;
        e.name = nm;
        e.val  = {ea, eb, era, erb, est, ebu};
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t       e;
        logic [9:0] act;
        if (q.size() > 0) begin
            e   = q.pop_front();
            act = {fwdA, fwdB, fwd_ra, fwd_rb, stall, bubble};
            total++;
            if (act === e.val)
                passed++;
            else
                $display("FAIL %s: got A=%0d B=%0d ra=%0d rb=%0d st=%0b bu=%0b, want A=%0d B=%0d ra=%0d rb=%0d st=%0b bu=%0b",
                         e.name, act[9:8], act[7:6], act[5:4], act[3:2], act[1], act[0],
                         e.val[9:8], e.val[7:6], e.val[5:4], e.val[3:2], e.val[1], e.val[0]);
        end
    end

    initial begin
        int waited;
        rst_n = 1'b0;
        {id_valid, id_ra, id_rb, id_use_ra, id_use_rb, id_wreg, id_regwrite, id_memread} = '0;
        {ex_srcA_reg, ex_srcB_reg, ex_flush} = '0;

        //    name         rs v ra rb ua ub wr rw mr sa sb fl  eA eB eRa eRb st bu
        step("rst_hold",   0, 1, 1, 1, 1, 1, 2, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        step("rst_hold2",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rel_first",  1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        step("idle1",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("idle2",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // MEM forward: r3 producer then reader of r3 on ra
        step("mem_prod",   1, 1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("mem_cons",   1, 1, 3, 0, 1, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("mem_fwd",    1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0);
        // WB forward: r5, unrelated, then reader of r5 on rb
        step("wb_prod",    1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("wb_mid",     1, 1, 7, 0, 1, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("wb_cons",    1, 1, 0, 5, 0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("wb_fwd",     1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2, 0, 0, 2, 0, 0);
        // Priority: r2 written twice back to back, then read on both sources
        step("pri_p1",     1, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("pri_p2",     1, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("pri_cons",   1, 1, 2, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("pri_fwd",    1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 1, 1, 0, 0);
        // Gating: srcA off hides fwd_rb from fwdA
        step("gate_prod",  1, 1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("gate_cons",  1, 1, 6, 6, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("gate_fwd",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 0, 0);
        step("gate_idle",  1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        // Load-use: LD r1 then reader of r1
        step("lu_load",    1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("lu_stall",   1, 1, 1, 0, 1, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step("lu_after",   1, 1, 1, 0, 1, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("lu_fwd",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 2, 0, 0, 0);
        // Flush beats load-use; killed load must not reach WB
        step("fl_load",    1, 1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("fl_vs_lu",   1, 1, 0, 2, 0, 1, 5, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        step("fl_next",    1, 1, 2, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        step("fl_killed",  1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        // Reset asserted in the middle of a stall cycle
        step("rs_load",    1, 1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rs_stall",   1, 1, 4, 0, 1, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        step("rs_mid",     0, 1, 4, 0, 1, 0, 5, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        step("rs_rel",     1, 1, 4, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        step("rs_idle1",   1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        step("rs_idle2",   1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);

        waited = 0;
        while (q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        if (q.size() > 0) begin
            total++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
